// File: rtl/prewish_debounce_n_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prewish_debounce_n_pkg
// Brief    : Shared command opcodes and report-byte layout for the debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package prewish_debounce_n_pkg;

  localparam int c_DAT_W           = 8;
  localparam int c_REPORT_FLAG_BIT = 7;
  localparam int c_MAX_BUTTONS     = 7;

  typedef enum logic [c_DAT_W-1:0] {
    CMD_QUERY   = 8'h00,
    CMD_ENABLE  = 8'h01,
    CMD_DISABLE = 8'h02
  } cmd_e;

endpackage
`default_nettype wire

// File: rtl/prewish_debounce_chan.sv
`default_nettype none
// ============================================================================
// Module   : prewish_debounce_chan
// Brief    : One button channel: two-flop synchroniser, tick-qualified
//            disagreement counter and debounced state.
// Revision : 1.0 - initial release
// ============================================================================
module prewish_debounce_chan #(
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_button,
  output logic o_state,
  output logic o_flip
);

  localparam int                 c_CNT_W    = $clog2(STABLE_TICKS + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_TICKS - 1);

  logic               r_meta;
  logic               r_sync;
  logic               r_state;
  logic [c_CNT_W-1:0] r_count;
  logic               w_disagree;
  logic               w_flip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_button;
      r_sync <= r_meta;
    end
  end

  assign w_disagree = r_sync ^ r_state;
  // Flip on the tick that would bring the count up to STABLE_TICKS.
  assign w_flip     = i_tick & w_disagree & (r_count == c_CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= 1'b0;
      r_count <= '0;
    end else if (i_tick) begin
      if (w_flip) begin
        r_state <= ~r_state;
        r_count <= '0;
      end else if (w_disagree) begin
        r_count <= r_count + c_CNT_W'(1);
      end else begin
        r_count <= '0;
      end
    end
  end

  assign o_state = r_state;
  assign o_flip  = w_flip;

endmodule
`default_nettype wire

// File: rtl/prewish_debounce_n.sv
`default_nettype none
// ============================================================================
// Module   : prewish_debounce_n
// Brief    : N-channel button debouncer with shared sample prescaler and a
//            strobe/byte command interface for queries and change reports.
// Revision : 1.0 - initial release
// ============================================================================
module prewish_debounce_n
  import prewish_debounce_n_pkg::*;
#(
  parameter int NUM_BUTTONS   = 3,
  parameter int PRESCALE_BITS = 17,
  parameter int STABLE_TICKS  = 4
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [NUM_BUTTONS-1:0] i_button,
  input  logic                   STB_I,
  input  logic [c_DAT_W-1:0]     DAT_I,
  output logic                   STB_O,
  output logic [c_DAT_W-1:0]     DAT_O,
  output logic                   o_alive
);

  logic [PRESCALE_BITS-1:0] r_prescale;
  logic [7:0]               r_tick_cnt;
  logic                     r_alive;
  logic                     r_report_en;
  logic                     r_stb;
  logic [c_DAT_W-1:0]       r_dat;

  logic                     w_tick;
  logic [NUM_BUTTONS-1:0]   w_state_vec;
  logic [NUM_BUTTONS-1:0]   w_flip_vec;
  logic [NUM_BUTTONS-1:0]   w_next_vec;
  logic [c_MAX_BUTTONS-1:0] w_vec_pad;
  logic                     w_query;
  logic                     w_report;
  logic                     w_emit;

  // Prescaler wraps naturally from all-ones to zero.
  assign w_tick = &r_prescale;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + PRESCALE_BITS'(1);
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_tick_cnt <= 8'd0;
      r_alive    <= 1'b0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + 8'd1;
      if (r_tick_cnt == 8'hFF) begin
        r_alive <= ~r_alive;
      end
    end
  end

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    prewish_debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_chan (
      .clk      (CLK_I),
      .rst      (RST_I),
      .i_tick   (w_tick),
      .i_button (i_button[g]),
      .o_state  (w_state_vec[g]),
      .o_flip   (w_flip_vec[g])
    );
  end

  // Reports and queries carry the vector as it stands after this edge.
  always_comb begin
    w_next_vec                     = w_state_vec ^ w_flip_vec;
    w_vec_pad                      = '0;
    w_vec_pad[NUM_BUTTONS-1:0]     = w_next_vec;
  end

  assign w_query  = STB_I && (DAT_I == CMD_QUERY);
  assign w_report = r_report_en && (|w_flip_vec);
  assign w_emit   = w_query || w_report;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_report_en <= 1'b1;
    end else if (STB_I) begin
      if (DAT_I == CMD_ENABLE) begin
        r_report_en <= 1'b1;
      end else if (DAT_I == CMD_DISABLE) begin
        r_report_en <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_stb <= 1'b0;
      r_dat <= '0;
    end else begin
      r_stb <= w_emit;
      if (w_emit) begin
        r_dat[c_REPORT_FLAG_BIT]   <= w_report;
        r_dat[c_MAX_BUTTONS-1:0]   <= w_vec_pad;
      end
    end
  end

  assign STB_O   = r_stb;
  assign DAT_O   = r_dat;
  assign o_alive = r_alive;

endmodule
`default_nettype wire
